// File: rtl/dmem_dump_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_dump_arbiter
//
// Shares the single data-memory port between the CPU MEM stage and a dump
// engine that streams every memory word (index 0..DEPTH-1) out over a
// valid/ready channel, so a memory snapshot can be taken in hardware.
//
// The CPU has priority. While the dump is waiting for the port (FETCH), each
// cycle the CPU wins bumps a starvation counter; once it reaches MAX_WAIT the
// dump takes the port for one cycle and the CPU is stalled for that cycle only.
// Each word is captured into dump_data on its grant cycle, so later CPU writes
// cannot disturb a beat that is waiting for the sink.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   cpu_re/cpu_we/cpu_addr/
//   cpu_wdata                   MEM-stage access request
//   cpu_rdata                   read data back to MEM stage (= mem_rdata)
//   cpu_stall                   CPU access not performed this cycle
//   dump_start                  one-cycle start pulse (ignored while busy)
//   dump_busy                   dump in progress (FETCH/HOLD/DONE)
//   dump_done                   one-cycle pulse after the last beat
//   dump_valid/dump_ready       beat handshake
//   dump_index/dump_data        word index and captured word of the beat
//   mem_re/mem_we/mem_addr/
//   mem_wdata/mem_rdata         data-memory port (combinational read)
// -----------------------------------------------------------------------------
module dmem_dump_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_done,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Starvation counter only needs to reach MAX_WAIT; it saturates there.
    localparam int STARVE_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_WAIT);
    localparam logic [ADDR_W-1:0]   LAST_IDX   = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_r;
    logic [ADDR_W-1:0]     idx_r;
    logic [STARVE_W-1:0]   starve_r;
    logic [DATA_W-1:0]     dump_data_r;
    logic                  busy_r;
    logic                  valid_r;
    logic                  done_r;

    logic                  cpu_req_s;
    logic                  starve_full_s;
    logic                  dump_grant_s;
    logic                  cpu_stall_s;

    // Arbitration: the dump only competes for the port while in FETCH.
    always_comb begin
        cpu_req_s     = cpu_re | cpu_we;
        starve_full_s = (starve_r == STARVE_MAX);
        dump_grant_s  = 1'b0;
        cpu_stall_s   = 1'b0;
        if (state_r == ST_FETCH) begin
            // Dump gets the port when the CPU is idle, or forcibly once starved.
            dump_grant_s = (~cpu_req_s) | starve_full_s;
            cpu_stall_s  = cpu_req_s & starve_full_s;
        end else begin
            dump_grant_s = 1'b0;
            cpu_stall_s  = 1'b0;
        end
    end

    // Memory port mux: dump reads its current index, otherwise pass the CPU through.
    always_comb begin
        mem_re    = cpu_re;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (dump_grant_s) begin
            // The dump never writes; a stalled CPU write is dropped this cycle.
            mem_re    = 1'b1;
            mem_we    = 1'b0;
            mem_addr  = idx_r;
            mem_wdata = {DATA_W{1'b0}};
        end else begin
            mem_re    = cpu_re;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Dump FSM: state, word index, starvation count, captured word and handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= {ADDR_W{1'b0}};
            starve_r    <= {STARVE_W{1'b0}};
            dump_data_r <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r  <= 1'b0;
                    valid_r <= 1'b0;
                    if (dump_start) begin
                        state_r  <= ST_FETCH;
                        idx_r    <= {ADDR_W{1'b0}};
                        starve_r <= {STARVE_W{1'b0}};
                        busy_r   <= 1'b1;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (dump_grant_s) begin
                        // Snapshot point for this word.
                        dump_data_r <= mem_rdata;
                        valid_r     <= 1'b1;
                        state_r     <= ST_HOLD;
                    end else if (!starve_full_s) begin
                        starve_r <= starve_r + STARVE_W'(1);
                    end else begin
                        starve_r <= starve_r;
                    end
                end
                ST_HOLD: begin
                    if (dump_ready) begin
                        valid_r <= 1'b0;
                        if (idx_r == LAST_IDX) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            idx_r    <= idx_r + ADDR_W'(1);
                            starve_r <= {STARVE_W{1'b0}};
                            state_r  <= ST_FETCH;
                        end
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign cpu_stall  = cpu_stall_s;
    assign dump_busy  = busy_r;
    assign dump_done  = done_r;
    assign dump_valid = valid_r;
    assign dump_index = idx_r;
    assign dump_data  = dump_data_r;

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_dump_arbiter
//
// Self-checking bench for dmem_dump_arbiter. A behavioural data memory sits on
// the mem_* port. The reference is procedural: for each word the bench walks
// the arbitration rules (CPU wins up to MAX_WAIT times, then the dump is
// granted), keeps its own copy of memory contents (ref_mem) updated only by
// CPU writes that were served, and predicts every beat from that copy.
// -----------------------------------------------------------------------------
module tb_dmem_dump_arbiter;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_re, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              dump_start, dump_busy, dump_done, dump_valid, dump_ready;
    logic [ADDR_W-1:0] dump_index;
    logic [DATA_W-1:0] dump_data;
    logic              mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic [DATA_W-1:0] mem       [0:DEPTH-1];
    logic [DATA_W-1:0] ref_mem   [0:DEPTH-1];
    logic [DATA_W-1:0] beat_data [0:DEPTH-1];
    int                beat_cyc  [0:DEPTH-1];

    int err_n = 0;
    int chk_n = 0;

    always #5 clk = ~clk;

    dmem_dump_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_done(dump_done),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_index(dump_index), .dump_data(dump_data),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory: combinational read, write on the clock edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Advance one clock; apply a CPU write to the reference only if it was served.
    task automatic step_cpu(input bit served);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit                w;
        a = cpu_addr; d = cpu_wdata; w = cpu_we;
        @(posedge clk);
        #2;
        if (served && w) ref_mem[a] = d;
    endtask

    // Choose the CPU request for one cycle according to the traffic mode.
    task automatic pick_cpu(input int mode, input bit in_fetch, input int idx,
                            input int nwait, input int hnum);
        int r;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
        cpu_wdata = $urandom();
        r = int'($urandom_range(0, 3));
        case (mode)
            1: cpu_re = 1'b1;
            2: begin
                cpu_re = (r == 1) || (r == 2);
                cpu_we = (r == 3);
            end
            3: begin
                if (in_fetch && idx == 9 && nwait == 0) begin
                    cpu_we = 1'b1; cpu_addr = 5'd9; cpu_wdata = 32'h0000_0055;
                end else if (!in_fetch && idx == 5 && hnum == 3) begin
                    cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdata = 32'h0000_00AA;
                end
            end
            default: ;
        endcase
    endtask

    // One full dump under the given traffic mode, checked cycle by cycle.
    // mode 0: CPU idle, ready=1; 1: CPU reads every cycle; 2: random traffic,
    // random ready, spurious starts; 3: directed hold/CPU-wins scenario.
    task automatic run_dump(input int mode, output int stalls, output int done_cyc);
        logic [DATA_W-1:0] snap;
        logic [10:0]       gv, ev;
        logic [40:0]       gh, eh;
        logic [38:0]       gm, em;
        int                cyc, nwait, hnum;
        bit                granted, forced, req, xfer;
        stalls = 0; done_cyc = -1; cyc = 0; snap = '0;

        // IDLE cycle carrying the start pulse; CPU still owns the port.
        pick_cpu(mode, 1'b0, 0, 0, 0);
        dump_start = 1'b1; dump_ready = 1'b1;
        #1;
        gm = {mem_re, mem_we, mem_addr, mem_wdata};
        em = {cpu_re, cpu_we, cpu_addr, cpu_wdata};
        chk_n++;
        if ({dump_valid, dump_busy, dump_done, cpu_stall, gm} !== {4'b0000, em}) begin
            err_n++;
            $display("FAIL start_cycle got=%h exp=%h", {dump_valid, dump_busy, dump_done, cpu_stall, gm}, {4'b0000, em});
        end
        step_cpu(1'b1);
        dump_start = 1'b0;
        cyc = 1;

        for (int i = 0; i < DEPTH; i++) begin
            nwait = 0; granted = 1'b0;
            while (!granted) begin
                pick_cpu(mode, 1'b1, i, nwait, 0);
                dump_start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                #1;
                if (cpu_stall === 1'b1) stalls++;
                req    = cpu_re | cpu_we;
                forced = req && (nwait == MAX_WAIT);
                if (!req || forced) begin
                    granted = 1'b1;
                    snap    = ref_mem[i];
                    gv = {dump_valid, dump_busy, dump_done, cpu_stall, mem_re, mem_we, mem_addr};
                    ev = {1'b0, 1'b1, 1'b0, forced, 1'b1, 1'b0, ADDR_W'(i)};
                    chk_n++;
                    if (gv !== ev) begin
                        err_n++;
                        $display("FAIL fetch_grant idx=%0d got=%b exp=%b", i, gv, ev);
                    end
                end else begin
                    gm = {mem_re, mem_we, mem_addr, mem_wdata};
                    em = {cpu_re, cpu_we, cpu_addr, cpu_wdata};
                    chk_n++;
                    if ({dump_valid, dump_busy, dump_done, cpu_stall, gm} !== {4'b0100, em}) begin
                        err_n++;
                        $display("FAIL fetch_cpu idx=%0d wait=%0d got=%h exp=%h", i, nwait,
                                 {dump_valid, dump_busy, dump_done, cpu_stall, gm}, {4'b0100, em});
                    end
                    if (cpu_re) begin
                        chk_n++;
                        if (cpu_rdata !== ref_mem[cpu_addr]) begin
                            err_n++;
                            $display("FAIL fetch_rdata addr=%0d got=%h exp=%h", cpu_addr, cpu_rdata, ref_mem[cpu_addr]);
                        end
                    end
                    nwait++;
                end
                step_cpu(!granted);
                cyc++;
            end

            hnum = 0; xfer = 1'b0;
            while (!xfer) begin
                pick_cpu(mode, 1'b0, i, 0, hnum);
                case (mode)
                    2:       dump_ready = 1'($urandom_range(0, 1));
                    3:       dump_ready = !(i == 5 && hnum < 10);
                    default: dump_ready = 1'b1;
                endcase
                dump_start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                #1;
                if (cpu_stall === 1'b1) stalls++;
                if (hnum == 0) beat_cyc[i] = (dump_valid === 1'b1) ? cyc : -1;
                gh = {dump_valid, dump_busy, dump_done, cpu_stall, dump_index, dump_data};
                eh = {4'b1100, ADDR_W'(i), snap};
                chk_n++;
                if (gh !== eh) begin
                    err_n++;
                    $display("FAIL hold_beat idx=%0d cyc=%0d got=%h exp=%h", i, hnum, gh, eh);
                end
                gm = {mem_re, mem_we, mem_addr, mem_wdata};
                em = {cpu_re, cpu_we, cpu_addr, cpu_wdata};
                chk_n++;
                if (gm !== em) begin
                    err_n++;
                    $display("FAIL hold_port idx=%0d got=%h exp=%h", i, gm, em);
                end
                if (cpu_re) begin
                    chk_n++;
                    if (cpu_rdata !== ref_mem[cpu_addr]) begin
                        err_n++;
                        $display("FAIL hold_rdata addr=%0d got=%h exp=%h", cpu_addr, cpu_rdata, ref_mem[cpu_addr]);
                    end
                end
                xfer = dump_ready;
                if (xfer) beat_data[i] = dump_data;
                step_cpu(1'b1);
                hnum++; cyc++;
            end
        end

        // DONE cycle.
        pick_cpu(mode, 1'b0, 0, 0, 0);
        dump_start = 1'b0; dump_ready = 1'b1;
        #1;
        if (cpu_stall === 1'b1) stalls++;
        if (dump_done === 1'b1) done_cyc = cyc;
        gm = {mem_re, mem_we, mem_addr, mem_wdata};
        em = {cpu_re, cpu_we, cpu_addr, cpu_wdata};
        chk_n++;
        if ({dump_valid, dump_busy, dump_done, cpu_stall, gm} !== {4'b0110, em}) begin
            err_n++;
            $display("FAIL done_cycle got=%h exp=%h", {dump_valid, dump_busy, dump_done, cpu_stall, gm}, {4'b0110, em});
        end
        step_cpu(1'b1);

        // Back in IDLE.
        cpu_re = 1'b0; cpu_we = 1'b0;
        #1;
        chk_n++;
        if ({dump_valid, dump_busy, dump_done, cpu_stall} !== 4'b0000) begin
            err_n++;
            $display("FAIL idle_after got=%b exp=0000", {dump_valid, dump_busy, dump_done, cpu_stall});
        end
    endtask

    // Fill memory through the CPU path while idle (pattern 0: 3*i, 1: random).
    task automatic load_mem(input int pattern);
        for (int i = 0; i < DEPTH; i++) begin
            cpu_re = 1'b0; cpu_we = 1'b1; dump_start = 1'b0;
            cpu_addr  = ADDR_W'(i);
            cpu_wdata = (pattern == 0) ? DATA_W'(3 * i) : $urandom();
            #1;
            chk_n++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, cpu_addr, cpu_wdata}) begin
                err_n++;
                $display("FAIL load_port i=%0d got=%h exp=%h", i, {mem_we, mem_addr, mem_wdata}, {1'b1, cpu_addr, cpu_wdata});
            end
            step_cpu(1'b1);
        end
        cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step_cpu(1'b0);
        for (int k = 0; k < 2; k++) begin
            cpu_re = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = ADDR_W'($urandom_range(0, DEPTH - 1)); cpu_wdata = $urandom();
            dump_start = 1'($urandom_range(0, 1)); dump_ready = 1'($urandom_range(0, 1));
            #1;
            chk_n++;
            if ({dump_busy, dump_done, dump_valid, cpu_stall, dump_index, dump_data} !== 41'd0) begin
                err_n++;
                $display("FAIL reset_outputs got=%h exp=0", {dump_busy, dump_done, dump_valid, cpu_stall, dump_index, dump_data});
            end
            chk_n++;
            if ({mem_re, mem_we, mem_addr, mem_wdata} !== {cpu_re, cpu_we, cpu_addr, cpu_wdata}) begin
                err_n++;
                $display("FAIL reset_port got=%h exp=%h", {mem_re, mem_we, mem_addr, mem_wdata}, {cpu_re, cpu_we, cpu_addr, cpu_wdata});
            end
            step_cpu(1'b0);
        end
        rst_n = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
        step_cpu(1'b0);
    endtask

    task automatic test_best_case();
        int st, dc;
        run_dump(0, st, dc);
        chk_n++;
        if (dc !== 65) begin
            err_n++;
            $display("FAIL best_done_cycle got=%0d exp=65", dc);
        end
        chk_n++;
        if (st !== 0) begin
            err_n++;
            $display("FAIL best_stalls got=%0d exp=0", st);
        end
        for (int k = 0; k < DEPTH; k++) begin
            chk_n++;
            if (beat_cyc[k] !== 2 * k + 2 || beat_data[k] !== DATA_W'(3 * k)) begin
                err_n++;
                $display("FAIL best_beat k=%0d got cyc=%0d data=%h exp cyc=%0d data=%h",
                         k, beat_cyc[k], beat_data[k], 2 * k + 2, DATA_W'(3 * k));
            end
        end
    endtask

    task automatic test_cpu_pressure();
        int st, dc;
        run_dump(1, st, dc);
        chk_n++;
        if (st !== DEPTH) begin
            err_n++;
            $display("FAIL pressure_stalls got=%0d exp=%0d", st, DEPTH);
        end
        for (int k = 0; k < DEPTH; k++) begin
            chk_n++;
            if (beat_data[k] !== DATA_W'(3 * k)) begin
                err_n++;
                $display("FAIL pressure_beat k=%0d got=%h exp=%h", k, beat_data[k], DATA_W'(3 * k));
            end
        end
    endtask

    task automatic test_hold_snapshot();
        int st, dc;
        run_dump(3, st, dc);
        chk_n++;
        if (beat_data[5] !== 32'd15) begin
            err_n++;
            $display("FAIL snap_beat5_old got=%h exp=%h", beat_data[5], 32'd15);
        end
        chk_n++;
        if (beat_data[9] !== 32'h0000_0055) begin
            err_n++;
            $display("FAIL cpu_wins_beat9 got=%h exp=%h", beat_data[9], 32'h0000_0055);
        end
        run_dump(0, st, dc);
        chk_n++;
        if (beat_data[5] !== 32'h0000_00AA) begin
            err_n++;
            $display("FAIL snap_beat5_new got=%h exp=%h", beat_data[5], 32'h0000_00AA);
        end
    endtask

    task automatic test_random();
        int st, dc;
        load_mem(1);
        for (int r = 0; r < 3; r++) begin
            run_dump(2, st, dc);
        end
        // Every served CPU write landed and no stalled one did.
        for (int i = 0; i < DEPTH; i++) begin
            cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = ADDR_W'(i); dump_start = 1'b0;
            #1;
            chk_n++;
            if (cpu_rdata !== ref_mem[i]) begin
                err_n++;
                $display("FAIL readback addr=%0d got=%h exp=%h", i, cpu_rdata, ref_mem[i]);
            end
            step_cpu(1'b1);
        end
        cpu_re = 1'b0;
    endtask

    task automatic test_abort();
        int st, dc;
        cpu_re = 1'b0; cpu_we = 1'b0; dump_ready = 1'b1; dump_start = 1'b1;
        step_cpu(1'b1);
        for (int c = 1; c <= 16; c++) begin
            dump_start = (c == 5);
            if (c == 16) rst_n = 1'b0;
            #1;
            if (c == 5) begin
                chk_n++;
                if (dump_busy !== 1'b1) begin
                    err_n++;
                    $display("FAIL abort_busy got=%b exp=1", dump_busy);
                end
            end
            if (c == 16) begin
                chk_n++;
                if ({dump_valid, dump_index, dump_data} !== {1'b1, 5'd7, ref_mem[7]}) begin
                    err_n++;
                    $display("FAIL abort_beat7 got=%h exp=%h", {dump_valid, dump_index, dump_data}, {1'b1, 5'd7, ref_mem[7]});
                end
            end
            step_cpu(1'b1);
        end
        dump_start = 1'b0;
        #1;
        chk_n++;
        if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
            err_n++;
            $display("FAIL abort_idle got=%b exp=000", {dump_valid, dump_busy, dump_done});
        end
        step_cpu(1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_n++;
            if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
                err_n++;
                $display("FAIL abort_no_done got=%b exp=000", {dump_valid, dump_busy, dump_done});
            end
            step_cpu(1'b1);
        end
        run_dump(0, st, dc);
        chk_n++;
        if (dc !== 65 || beat_data[0] !== ref_mem[0]) begin
            err_n++;
            $display("FAIL restart got done=%0d beat0=%h exp done=65 beat0=%h", dc, beat_data[0], ref_mem[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dump_start = 1'b0; dump_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0; beat_data[i] = '0; beat_cyc[i] = 0;
        end
        test_reset();
        load_mem(0);
        test_best_case();
        test_cpu_pressure();
        test_hold_snapshot();
        test_random();
        test_abort();
        $display("Result: errors=%0d of %0d checks", err_n, chk_n);
        $finish;
    end

endmodule
